// File: rtl/battle_datapath_if.sv
// Strobe/result bundle between the battle control FSM (master) and battle_datapath (slave).
// TYPE_EFFECT_EN adds the eff result field.
interface battle_datapath_if #(
    parameter int HP_W = 4
);
    logic [1:0]      p_move;
    logic            calc_damage;
    logic            active_trainer;
    logic            apply_damage;
    logic            target;
    logic            rng_bypass;
    logic [HP_W-1:0] p_hp;
    logic [HP_W-1:0] ai_hp;
    logic [HP_W-1:0] last_damage;
    logic            crit;
    logic [3:0]      pp_empty;
`ifdef TYPE_EFFECT_EN
    logic [1:0]      eff;

    modport master (
        output p_move, calc_damage, active_trainer, apply_damage, target, rng_bypass,
        input  p_hp, ai_hp, last_damage, crit, pp_empty, eff
    );
    modport slave (
        input  p_move, calc_damage, active_trainer, apply_damage, target, rng_bypass,
        output p_hp, ai_hp, last_damage, crit, pp_empty, eff
    );
`else
    modport master (
        output p_move, calc_damage, active_trainer, apply_damage, target, rng_bypass,
        input  p_hp, ai_hp, last_damage, crit, pp_empty
    );
    modport slave (
        input  p_move, calc_damage, active_trainer, apply_damage, target, rng_bypass,
        output p_hp, ai_hp, last_damage, crit, pp_empty
    );
`endif
endinterface

// File: rtl/battle_datapath.sv
// Battle datapath: HP, PP, Galois LFSR and latched damage for the battle FSM.
// Optional type effectiveness is enabled with the TYPE_EFFECT_EN macro.
module battle_datapath #(
    parameter int         HP_W      = 4,
    parameter int         P_MAX_HP  = 15,
    parameter int         AI_MAX_HP = 15,
    parameter int         PP_INIT   = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
`ifdef TYPE_EFFECT_EN
    ,
    parameter logic [1:0] P_TYPE    = 2'd0,
    parameter logic [1:0] AI_TYPE   = 2'd1
`endif
) (
    input  logic          clk,
    input  logic          reset,
    battle_datapath_if.slave bus
);
    localparam int PP_W  = $clog2(PP_INIT + 1);
    localparam int EXT_W = HP_W + 3;
    localparam logic [EXT_W-1:0] DMG_MAX = EXT_W'((1 << HP_W) - 1);

    logic [7:0]      lfsr;
    logic [7:0]      lfsr_next;
    logic [PP_W-1:0] pp [4];
    logic [HP_W-1:0] p_hp;
    logic [HP_W-1:0] ai_hp;
    logic [HP_W-1:0] dmg_reg;
    logic            crit_reg;
    logic [1:0]      move;
    logic [2:0]      base;
    logic            variance;
    logic            crit_roll;
    logic [EXT_W-1:0] raw;
    logic [EXT_W-1:0] scaled;
    logic [HP_W-1:0] dmg_next;
    logic [HP_W-1:0] tgt_hp;
    logic [HP_W-1:0] tgt_hp_next;
    logic [3:0]      pp_empty;
`ifdef TYPE_EFFECT_EN
    logic [1:0]      eff_reg;
    logic [1:0]      eff_next;
    logic [1:0]      atk_type;
    logic [1:0]      def_type;
    logic [EXT_W-1:0] halved;

    function automatic logic [1:0] next_type(input logic [1:0] t);
        return (t == 2'd2) ? 2'd0 : t + 2'd1;
    endfunction
`endif

    // Right-shift Galois form of x^8+x^6+x^5+x^4+1.
    assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[7:1]} ^ 8'hB8) : {1'b0, lfsr[7:1]};

    always_comb begin
        move = bus.active_trainer ? (bus.rng_bypass ? 2'd0 : lfsr[1:0]) : bus.p_move;
        case (move)
            2'd0:    base = 3'd2;
            2'd1:    base = 3'd3;
            2'd2:    base = 3'd4;
            default: base = 3'd1;
        endcase
        if (!bus.active_trainer && pp[bus.p_move] == '0)
            base = 3'd1;
        variance  = lfsr[2] & ~bus.rng_bypass;
        crit_roll = (lfsr[7:5] == 3'b111) & ~bus.rng_bypass;
        raw = EXT_W'(base) + EXT_W'(variance);
        if (crit_roll)
            raw = raw << 1;
`ifdef TYPE_EFFECT_EN
        case (move)
            2'd1:    atk_type = 2'd1;
            2'd2:    atk_type = 2'd2;
            default: atk_type = 2'd0;
        endcase
        def_type = bus.active_trainer ? P_TYPE : AI_TYPE;
        halved   = (raw >> 1 == '0) ? EXT_W'(1) : raw >> 1;
        if (next_type(atk_type) == def_type) begin
            scaled   = raw << 1;
            eff_next = 2'b01;
        end else if (next_type(def_type) == atk_type) begin
            scaled   = halved;
            eff_next = 2'b10;
        end else begin
            scaled   = raw;
            eff_next = 2'b00;
        end
`else
        scaled = raw;
`endif
        dmg_next = (scaled > DMG_MAX) ? DMG_MAX[HP_W-1:0] : scaled[HP_W-1:0];

        tgt_hp      = bus.target ? ai_hp : p_hp;
        tgt_hp_next = (dmg_reg >= tgt_hp) ? '0 : tgt_hp - dmg_reg;

        for (int unsigned i = 0; i < 4; i++)
            pp_empty[i] = (pp[i] == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            p_hp     <= HP_W'(P_MAX_HP);
            ai_hp    <= HP_W'(AI_MAX_HP);
            dmg_reg  <= '0;
            crit_reg <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                pp[i] <= PP_W'(PP_INIT);
`ifdef TYPE_EFFECT_EN
            eff_reg  <= 2'b00;
`endif
        end else begin
            lfsr <= lfsr_next;
            // Apply reads dmg_reg before this edge's calc overwrites it.
            if (bus.apply_damage) begin
                if (bus.target)
                    ai_hp <= tgt_hp_next;
                else
                    p_hp  <= tgt_hp_next;
            end
            if (bus.calc_damage) begin
                dmg_reg  <= dmg_next;
                crit_reg <= crit_roll;
`ifdef TYPE_EFFECT_EN
                eff_reg  <= eff_next;
`endif
                if (!bus.active_trainer && pp[bus.p_move] != '0)
                    pp[bus.p_move] <= pp[bus.p_move] - 1'b1;
            end
        end
    end

    assign bus.p_hp        = p_hp;
    assign bus.ai_hp       = ai_hp;
    assign bus.last_damage = dmg_reg;
    assign bus.crit        = crit_reg;
    assign bus.pp_empty    = pp_empty;
`ifdef TYPE_EFFECT_EN
    assign bus.eff         = eff_reg;
`endif
endmodule

// File: tb/tb_battle_datapath.sv
// Directed, scoreboarded bench for battle_datapath (default build, no type effects).
module tb_battle_datapath;
    typedef struct {
        logic [3:0] dmg;
        logic       crit;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] lfsr_m;
    int         pp_m [4];
    int         p_m, ai_m, dmg_m;
    exp_t       sb [$];

    battle_datapath_if #(.HP_W(4)) bus ();

    battle_datapath #(
        .HP_W(4), .P_MAX_HP(15), .AI_MAX_HP(15), .PP_INIT(3), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped in lockstep with the DUT clock and reset.
    always @(posedge clk or posedge reset) begin
        if (reset)
            lfsr_m <= 8'hA5;
        else if (lfsr_m[0])
            lfsr_m <= (lfsr_m >> 1) ^ 8'hB8;
        else
            lfsr_m <= lfsr_m >> 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < 4; i++) pp_m[i] = 3;
        p_m   = 15;
        ai_m  = 15;
        dmg_m = 0;
        sb.delete();
    endtask

    function automatic exp_t model_calc(input logic [7:0] l, input logic at,
                                        input logic [1:0] mv, input logic byp);
        exp_t e;
        int   m, b, v, r;
        m = at ? (byp ? 0 : int'(l[1:0])) : int'(mv);
        case (m)
            0: b = 2;
            1: b = 3;
            2: b = 4;
            default: b = 1;
        endcase
        if (!at && pp_m[mv] == 0) b = 1;
        v = byp ? 0 : int'(l[2]);
        e.crit = !byp && (l[7:5] == 3'b111);
        r = (b + v) * (e.crit ? 2 : 1);
        if (r > 15) r = 15;
        e.dmg = 4'(r);
        return e;
    endfunction

    function automatic logic [3:0] pp_empty_m();
        logic [3:0] pe;
        for (int i = 0; i < 4; i++) pe[i] = (pp_m[i] == 0);
        return pe;
    endfunction

    task automatic cyc(input logic c, input logic at, input logic [1:0] mv,
                       input logic a, input logic tg, input logic byp);
        exp_t e;
        @(negedge clk);
        bus.calc_damage    = c;
        bus.active_trainer = at;
        bus.p_move         = mv;
        bus.apply_damage   = a;
        bus.target         = tg;
        bus.rng_bypass     = byp;
        if (a) begin
            if (tg) ai_m = (ai_m > dmg_m) ? ai_m - dmg_m : 0;
            else    p_m  = (p_m  > dmg_m) ? p_m  - dmg_m : 0;
        end
        if (c) begin
            e = model_calc(lfsr_m, at, mv, byp);
            sb.push_back(e);
            if (!at && pp_m[mv] > 0) pp_m[mv]--;
            dmg_m = e.dmg;
        end
        @(posedge clk);
        #1;
        if (c) begin
            e = sb.pop_front();
            check("last_damage", 8'(bus.last_damage), 8'(e.dmg));
            check("crit", 8'(bus.crit), 8'(e.crit));
        end
        check("p_hp", 8'(bus.p_hp), 8'(p_m));
        check("ai_hp", 8'(bus.ai_hp), 8'(ai_m));
        check("pp_empty", 8'(bus.pp_empty), 8'(pp_empty_m()));
    endtask

    // Reset lands while calc and apply are both pending; neither may take effect.
    task automatic mid_op_reset();
        @(negedge clk);
        bus.calc_damage    = 1'b1;
        bus.active_trainer = 1'b0;
        bus.p_move         = 2'd2;
        bus.apply_damage   = 1'b1;
        bus.target         = 1'b1;
        bus.rng_bypass     = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_p_hp", 8'(bus.p_hp), 8'd15);
        check("rst_ai_hp", 8'(bus.ai_hp), 8'd15);
        check("rst_last_damage", 8'(bus.last_damage), 8'd0);
        check("rst_crit", 8'(bus.crit), 8'd0);
        check("rst_pp_empty", 8'(bus.pp_empty), 8'd0);
        @(posedge clk);
        #1;
        check("rst_hold_ai_hp", 8'(bus.ai_hp), 8'd15);
        @(negedge clk);
        reset              = 1'b0;
        bus.calc_damage    = 1'b0;
        bus.apply_damage   = 1'b0;
        reset_models();
    endtask

    initial begin
        reset              = 1'b1;
        bus.calc_damage    = 1'b0;
        bus.active_trainer = 1'b0;
        bus.p_move         = 2'd0;
        bus.apply_damage   = 1'b0;
        bus.target         = 1'b0;
        bus.rng_bypass     = 1'b1;
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        check("init_p_hp", 8'(bus.p_hp), 8'd15);
        check("init_ai_hp", 8'(bus.ai_hp), 8'd15);
        check("init_last_damage", 8'(bus.last_damage), 8'd0);
        check("init_pp_empty", 8'(bus.pp_empty), 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic player attack, then simultaneous calc/apply with dmg_reg=3.
        cyc(1, 0, 2'd2, 0, 0, 1);
        check("basic_dmg", 8'(bus.last_damage), 8'd4);
        cyc(0, 0, 2'd0, 1, 1, 1);
        check("basic_ai_hp", 8'(bus.ai_hp), 8'd11);
        cyc(1, 0, 2'd1, 0, 0, 1);
        check("simul_pre_dmg", 8'(bus.last_damage), 8'd3);
        cyc(1, 0, 2'd0, 1, 1, 1);
        check("simul_ai_hp", 8'(bus.ai_hp), 8'd8);
        check("simul_new_dmg", 8'(bus.last_damage), 8'd2);
        cyc(0, 0, 2'd0, 0, 0, 1);
        check("idle_hold_dmg", 8'(bus.last_damage), 8'd2);

        mid_op_reset();

        // PP exhaustion on move 1, fourth calc falls back to struggle.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 2'd1, 0, 0, 1);
            check("pp_ex_dmg", 8'(bus.last_damage), (i < 3) ? 8'd3 : 8'd1);
            check("pp_ex_empty1", 8'(bus.pp_empty[1]), (i >= 2) ? 8'd1 : 8'd0);
        end
        cyc(1, 0, 2'd1, 0, 0, 1);
        check("pp_stays_empty", 8'(bus.pp_empty), 8'b0010);

        mid_op_reset();

        // Drain player HP to zero and confirm it stays there.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, (i < 3) ? 2'd2 : 2'd0, 0, 0, 1);
            cyc(0, 0, 2'd0, 1, 0, 1);
        end
        check("sat_p_hp", 8'(bus.p_hp), 8'd0);
        cyc(0, 0, 2'd0, 1, 0, 1);
        check("sat_hold_p_hp", 8'(bus.p_hp), 8'd0);

        mid_op_reset();

        // Random AI calcs against the reference LFSR, with a reset halfway.
        for (int i = 0; i < 64; i++) begin
            if (i == 32) mid_op_reset();
            cyc(1, 1, 2'd0, i[0], 1'b0, 0);
        end
        for (int i = 0; i < 16; i++)
            cyc(1, 0, 2'($urandom_range(0, 3)), i[0], 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
